// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU bus controller. It decodes each access into RAM, wait-stated ROM
// or a two-register I/O block, and completes every access with a one-cycle ready strobe.
// The I/O block fronts a 4-entry TX FIFO that a downstream consumer drains.
module mem_bus_ctrl #(
  parameter int         ROM_WAIT = 2,
  parameter logic [7:0] IO_BASE  = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       ready,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {RGN_RAM, RGN_ROM, RGN_IO_DATA, RGN_IO_STAT} region_t;

  localparam logic [7:0] IO_STAT      = IO_BASE + 8'd1;
  localparam bit         ROM_HAS_WAIT = (ROM_WAIT > 0);
  // The counter counts down to zero, so it starts one below the wait-state count.
  localparam logic [2:0] WAIT_LOAD    = ROM_HAS_WAIT ? 3'(ROM_WAIT - 1) : 3'd0;

  state_t     state;
  logic [2:0] wait_cnt;
  logic       acc_rw;
  region_t    acc_region;
  logic [7:0] acc_wdata;

  region_t    cur_region;
  logic [7:0] read_value;
  logic       io_stall;

  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // RAM sees the CPU address and data directly.
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  assign fifo_full  = (fifo_count == 3'd4);
  assign fifo_empty = (fifo_count == 3'd0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // A write reaches the FIFO as its access finishes. The push is guarded by full
  // even though acceptance already ensured there is room.
  assign push = (state == DONE) && acc_rw && (acc_region == RGN_IO_DATA) && !fifo_full;
  assign pop  = tx_ready && !fifo_empty;

  // An I/O data write cannot be accepted while the FIFO is full. The decision uses the
  // registered count, so a pop on the same edge does not help until the next cycle.
  assign io_stall = cpu_rw && (cur_region == RGN_IO_DATA) && fifo_full;

  // Region of the address currently presented. I/O decode takes priority over ROM.
  always_comb begin
    cur_region = RGN_RAM;
    if (cpu_addr == IO_BASE) begin
      cur_region = RGN_IO_DATA;
    end else if (cpu_addr == IO_STAT) begin
      cur_region = RGN_IO_STAT;
    end else if (cpu_addr[7:4] == 4'hF) begin
      cur_region = RGN_ROM;
    end
  end

  // Read data for accesses that finish one cycle after acceptance.
  always_comb begin
    read_value = mem_rdata;
    case (cur_region)
      RGN_IO_DATA: read_value = 8'h00;
      RGN_IO_STAT: read_value = {6'b0, fifo_full, fifo_empty};
      default:     read_value = mem_rdata;
    endcase
  end

  // Access sequencer. Outputs are registered, so ready and mem_we are high exactly
  // while the FSM is in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      ready      <= 1'b0;
      mem_we     <= 1'b0;
      cpu_rdata  <= 8'h00;
      acc_rw     <= 1'b0;
      acc_region <= RGN_RAM;
      acc_wdata  <= 8'h00;
    end else begin
      ready  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req && !io_stall) begin
            acc_rw     <= cpu_rw;
            acc_region <= cur_region;
            acc_wdata  <= cpu_wdata;
            if ((cur_region == RGN_ROM) && ROM_HAS_WAIT) begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state  <= DONE;
              ready  <= 1'b1;
              mem_we <= cpu_rw && (cur_region == RGN_RAM);
              if (!cpu_rw) begin
                cpu_rdata <= read_value;
              end
            end
          end
        end
        WAIT: begin
          if (!cpu_req) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt == 3'd0) begin
            state <= DONE;
            ready <= 1'b1;
            if (!acc_rw) begin
              cpu_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // TX FIFO storage and pointers. A simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= acc_wdata;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed and randomized checks of mem_bus_ctrl. A transaction-level
// model tracks latency, RAM contents and the TX FIFO as a queue.
module tb_mem_bus_ctrl;

  localparam int         ROM_WAIT = 2;
  localparam logic [7:0] IO_BASE  = 8'hE0;
  localparam logic [7:0] IO_STAT  = IO_BASE + 8'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req;
  logic       cpu_rw;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       ready;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int total = 0;
  int bad   = 0;

  logic       init_mem = 1'b1;
  logic       check_on = 1'b0;
  int         tx_mode  = 0;
  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] pop_log [$];

  // Reference model state, valid for the cycle following each rising edge.
  logic [7:0] fifo_q [$];
  logic       exp_ready = 1'b0;
  logic       exp_we    = 1'b0;
  logic       exp_read  = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  int         lat;
  logic [7:0] rd;

  mem_bus_ctrl #(.ROM_WAIT(ROM_WAIT), .IO_BASE(IO_BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seedVal(input int i);
    return 8'((i * 73 + 29) ^ (i >> 3));
  endfunction

  // External RAM device: combinational read, written on the strobe.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) ram[i] <= seedVal(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Consumer side: tx_ready is held low, held high, or randomized, depending on tx_mode.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (tx_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Log every byte the consumer takes.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && tx_valid && tx_ready) pop_log.push_back(tx_data);
    end
  end

  // Transaction model. An accepted access completes 1 cycle later, or ROM_WAIT+1 cycles
  // later for ROM, unless the request is dropped first.
  initial begin : model
    int         pre_count;
    bit         busy;
    int         left;
    bit         acc_rw;
    logic [7:0] acc_addr;
    logic [7:0] acc_wdata;
    bit         fin;
    bit         n_ready;
    bit         n_we;
    busy = 0;
    left = 0;
    acc_rw = 0;
    acc_addr = 8'h00;
    acc_wdata = 8'h00;
    forever begin
      @(posedge clk);
      pre_count = fifo_q.size();
      if (init_mem) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = seedVal(i);
      end
      if (exp_we) ref_mem[cpu_addr] = cpu_wdata;
      if (rst) begin
        fifo_q.delete();
        busy      = 0;
        exp_ready = 1'b0;
        exp_we    = 1'b0;
        exp_read  = 1'b0;
      end else begin
        if (pre_count > 0 && tx_ready) void'(fifo_q.pop_front());
        if (exp_ready && acc_rw && acc_addr == IO_BASE) fifo_q.push_back(acc_wdata);
        fin = 0;
        n_ready = 0;
        n_we = 0;
        if (busy) begin
          if (!cpu_req) begin
            busy = 0;
          end else if (left == 1) begin
            busy = 0;
            fin  = 1;
          end else begin
            left--;
          end
        end else if (!exp_ready && cpu_req) begin
          if (!(cpu_rw && cpu_addr == IO_BASE && pre_count == 4)) begin
            acc_rw    = cpu_rw;
            acc_addr  = cpu_addr;
            acc_wdata = cpu_wdata;
            if (cpu_addr >= 8'hF0 && ROM_WAIT > 0) begin
              busy = 1;
              left = ROM_WAIT;
            end else begin
              fin = 1;
            end
          end
        end
        if (fin) begin
          n_ready  = 1;
          n_we     = acc_rw && acc_addr < 8'hF0 && acc_addr != IO_BASE && acc_addr != IO_STAT;
          exp_read = !acc_rw;
          if (acc_addr == IO_BASE) exp_rdata = 8'h00;
          else if (acc_addr == IO_STAT) exp_rdata = {6'b0, pre_count == 4, pre_count == 0};
          else exp_rdata = ref_mem[cpu_addr];
        end
        exp_ready = n_ready;
        exp_we    = n_we;
      end
    end
  end

  // Compare the DUT against the model every cycle, shortly after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (check_on) begin
        checkOutput("ready", ready, exp_ready);
        checkOutput("mem_we", mem_we, exp_we);
        checkOutput("tx_valid", tx_valid, fifo_q.size() != 0);
        checkOutput("tx_data", tx_data, (fifo_q.size() != 0) ? fifo_q[0] : 8'h00);
        checkOutput("mem_addr", mem_addr, cpu_addr);
        checkOutput("mem_wdata", mem_wdata, cpu_wdata);
        if (exp_ready && exp_read) checkOutput("cpu_rdata", cpu_rdata, exp_rdata);
      end
    end
  end

  // One CPU access. Must be called at a falling edge. lat counts falling edges until
  // ready is seen (-1 if the request was dropped first).
  task automatic applyStimulus(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                               input int gap, input int abort_after,
                               output int lat_o, output logic [7:0] rdata_o);
    int n;
    cpu_req = 1'b0;
    repeat (gap) @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat_o   = -1;
    rdata_o = 8'h00;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (ready) begin
        lat_o   = n;
        rdata_o = cpu_rdata;
        break;
      end
      if (abort_after != 0 && n == abort_after) break;
      if (n >= 200) begin
        total++;
        bad++;
        $display("[TB] FAIL access_timeout: got no ready, required ready within 200 cycles (addr %0h)", addr);
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_rw    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_mem_we", mem_we, 0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 8'h00);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    init_mem = 1'b0;
    rst      = 1'b0;
    check_on = 1'b1;

    // RAM write and read-back
    applyStimulus(1'b1, 8'h10, 8'hA5, 1, 0, lat, rd);
    checkOutput("ram_write_latency", lat, 1);
    applyStimulus(1'b0, 8'h10, 8'h00, 1, 0, lat, rd);
    checkOutput("ram_read_latency", lat, 1);
    checkOutput("ram_read_data", rd, 8'hA5);

    // ROM read and ignored write
    applyStimulus(1'b0, 8'hF3, 8'h00, 1, 0, lat, rd);
    checkOutput("rom_read_latency", lat, 3);
    applyStimulus(1'b1, 8'hF3, 8'h5A, 1, 0, lat, rd);
    checkOutput("rom_write_latency", lat, 3);

    // Status register and FIFO fill
    applyStimulus(1'b0, IO_STAT, 8'h00, 1, 0, lat, rd);
    checkOutput("status_empty", rd, 8'h01);
    applyStimulus(1'b1, IO_BASE, 8'h01, 1, 0, lat, rd);
    checkOutput("io_write_latency", lat, 1);
    applyStimulus(1'b0, IO_STAT, 8'h00, 1, 0, lat, rd);
    checkOutput("status_one_entry", rd, 8'h00);
    applyStimulus(1'b0, IO_BASE, 8'h00, 1, 0, lat, rd);
    checkOutput("io_data_read", rd, 8'h00);
    for (int v = 2; v <= 4; v++) applyStimulus(1'b1, IO_BASE, 8'(v), 1, 0, lat, rd);
    applyStimulus(1'b0, IO_STAT, 8'h00, 1, 0, lat, rd);
    checkOutput("status_full", rd, 8'h02);

    // Fifth write stalls until the consumer starts draining
    pop_log.delete();
    fork
      applyStimulus(1'b1, IO_BASE, 8'h05, 1, 0, lat, rd);
      begin
        repeat (5) @(posedge clk);
        tx_mode = 1;
      end
    join
    checkOutput("stall_latency", lat, 6);
    repeat (12) @(negedge clk);
    checkOutput("pop_count", pop_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++) checkOutput("pop_order", pop_log[i], 8'(i + 1));

    // Request dropped during ROM wait
    tx_mode = 0;
    applyStimulus(1'b0, 8'hF3, 8'h00, 1, 1, lat, rd);
    checkOutput("rom_abort_no_ready", lat, -1);
    applyStimulus(1'b0, 8'h10, 8'h00, 1, 0, lat, rd);
    checkOutput("after_abort_latency", lat, 1);
    checkOutput("after_abort_data", rd, 8'hA5);

    // Reset during a full-FIFO stall
    for (int v = 0; v < 4; v++) applyStimulus(1'b1, IO_BASE, 8'(8'hA0 + v), 1, 0, lat, rd);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rw    = 1'b1;
    cpu_addr  = IO_BASE;
    cpu_wdata = 8'hEE;
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_stall_tx_valid", tx_valid, 0);
    checkOutput("rst_stall_ready", ready, 0);
    applyStimulus(1'b0, 8'h10, 8'h00, 1, 0, lat, rd);
    checkOutput("after_rst_latency", lat, 1);

    // Randomized traffic
    tx_mode = 2;
    for (int k = 0; k < 400; k++) begin
      int         sel;
      logic [7:0] a;
      sel = $urandom_range(0, 9);
      a   = 8'($urandom_range(0, 8'hDF));
      if (sel >= 4 && sel <= 5) a = 8'hF0 | 8'($urandom_range(0, 15));
      else if (sel >= 6 && sel <= 7) a = IO_BASE;
      else if (sel == 8) a = IO_STAT;
      else if (sel == 9) a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
                    lat, rd);
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter ROM_WAIT, default 2, wait states inserted for accesses to 8'hF0-8'hFF (range 0-7).
REQ-002 Parameter IO_BASE, default 8'hE0, address of TX data register; IO_BASE+1 is the status register.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  CPU access request; held high until ready.
REQ-006 cpu_rw  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  8  CPU byte address.
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 cpu_rdata  out  8  read data, valid while ready high.
REQ-010 ready  out  1  one-cycle access-complete strobe to CPU.
REQ-011 mem_addr  out  8  RAM address, equal to cpu_addr (combinational).
REQ-012 mem_we  out  1  RAM write strobe, one cycle.
REQ-013 mem_wdata  out  8  RAM write data, equal to cpu_wdata.
REQ-014 mem_rdata  in  8  RAM read data, combinational from mem_addr.
REQ-015 tx_data  out  8  head entry of TX FIFO.
REQ-016 tx_valid  out  1  TX FIFO non-empty.
REQ-017 tx_ready  in  1  consumer pops head when tx_valid & tx_ready at clock edge.

Function
REQ-018 FSM states IDLE, WAIT, DONE; IDLE moves on cpu_req=1: to DONE for RAM/IO regions, to WAIT for ROM region (or to DONE if ROM_WAIT=0).
REQ-019 Region decode at IDLE acceptance: IO = IO_BASE or IO_BASE+1; ROM = 8'hF0-8'hFF; RAM = all other addresses.
REQ-020 WAIT holds a down-counter loaded with ROM_WAIT-1; on zero -> DONE; counter width 3 bits.
REQ-021 DONE asserts ready=1 for exactly one cycle, then returns to IDLE; new request may be accepted on the following cycle.
REQ-022 Latency: RAM/IO = ready in cycle after acceptance; ROM = ready ROM_WAIT+1 cycles after acceptance.
REQ-023 RAM write: mem_we=1 only in the DONE cycle; RAM read: cpu_rdata = mem_rdata sampled at the DONE cycle.
REQ-024 ROM write: ignored, mem_we stays 0, ready still issued; ROM read identical to RAM read.
REQ-025 IO_BASE write: pushes cpu_wdata into 4-entry FIFO in DONE cycle; IO_BASE read returns 8'h00.
REQ-026 IO_BASE+1 read returns {6'b0, full, empty}; writes to IO_BASE+1 ignored, ready issued.
REQ-027 IO_BASE write with FIFO full: FSM stays in IDLE-stall (ready=0) until not full; pop in the same cycle does not free space for that cycle's decision.
REQ-028 FIFO pointers 2 bits, wrap 3->0; count 0-4; push and pop in same cycle on non-full non-empty FIFO leaves count unchanged.
REQ-029 Pop on empty FIFO ignored; tx_data undefined-free: reads 8'h00 when empty.
REQ-030 cpu_req dropped before DONE: access aborted, FSM -> IDLE, no write, no push, no ready.
REQ-031 cpu_addr/cpu_rw/cpu_wdata captured at acceptance; changes mid-access do not affect region or operation.

Reset
REQ-032 rst=1 at a clock edge: state=IDLE, counter=0, FIFO empty, pointers=0, ready=0, mem_we=0, cpu_rdata=8'h00, tx_valid=0.
REQ-033 rst mid-access or mid-stall: access discarded, no ready issued, no write, FIFO contents lost.

Verification
REQ-034 RAM write 8'h10<=8'hA5 then read 8'h10 -> ready 1 cycle after each acceptance, mem_we one cycle, cpu_rdata=8'hA5.
REQ-035 Read 8'hF3 with ROM_WAIT=2 -> ready exactly 3 cycles after acceptance; write 8'hF3 -> mem_we never asserted.
REQ-036 Five writes 8'h01..8'h05 to IO_BASE, tx_ready=0 -> first four complete, fifth stalls, status read (after 4) would show full; set tx_ready=1 -> fifth completes, tx_data sequence 01,02,03,04,05.
REQ-037 Empty FIFO: read IO_BASE+1 -> cpu_rdata=8'h01; after one push -> 8'h00.
REQ-038 Drop cpu_req during ROM WAIT -> no ready, FSM IDLE next cycle; new RAM request completes normally.
REQ-039 Assert rst during IO stall with 4 entries -> next cycle tx_valid=0, ready=0, state IDLE.
